// File: rtl/vsid_cam_update_ctrl.sv
// vsid_cam_update_ctrl: owns the live VSID/MAC match table of the parser.
// Updates commit only between packets. Option macro: VSID_CAM_BULK_CLEAR_EN.
module vsid_cam_update_ctrl #(
  parameter  int AXIS_ID_WIDTH  = 4,
  parameter  int WAIT_CNT_WIDTH = 16,
  localparam int PER_ID         = 82,
  localparam int NUM_AXIS_ID    = 2 ** AXIS_ID_WIDTH
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          cfg_req_valid,
  output logic                          cfg_req_ready,
  input  logic [AXIS_ID_WIDTH-1:0]      cfg_req_id,
  input  logic [31:0]                   cfg_req_vsid,
  input  logic                          cfg_req_vsid_must_match,
  input  logic [47:0]                   cfg_req_mac,
  input  logic                          cfg_req_mac_must_match,
`ifdef VSID_CAM_BULK_CLEAR_EN
  input  logic                          cfg_req_clear,
`endif
  output logic                          cfg_done,
  output logic [WAIT_CNT_WIDTH-1:0]     cfg_wait_cycles,
  input  logic                          mon_tvalid,
  input  logic                          mon_tready,
  input  logic                          mon_tlast,
  output logic                          stream_hold,
  output logic [PER_ID*NUM_AXIS_ID-1:0] vsid_cam_values
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic [1:0]                      state_q;
  logic [1:0]                      state_d;
  logic                            in_pkt_q;
  logic                            acc;
  logic                            boundary;
  logic                            req_hs;
  logic [AXIS_ID_WIDTH-1:0]        sh_id_q;
  logic [PER_ID-1:0]               sh_entry_q;
  logic                            sh_clr_q;
  logic                            req_clr;
  logic [WAIT_CNT_WIDTH-1:0]       wait_cnt_q;
  logic [PER_ID*NUM_AXIS_ID-1:0]   tab_q;

`ifdef VSID_CAM_BULK_CLEAR_EN
  assign req_clr = cfg_req_clear;
`else
  assign req_clr = 1'b0;
`endif

  assign acc      = mon_tvalid & mon_tready;
  assign boundary = ~in_pkt_q & ~acc;
  assign req_hs   = (state_q == ST_IDLE) & cfg_req_valid;

  assign cfg_req_ready   = (state_q == ST_IDLE);
  assign stream_hold     = (state_q != ST_IDLE);
  assign cfg_done        = (state_q == ST_COMMIT);
  assign vsid_cam_values = tab_q;

  // Track whether the parser is inside a packet (after first beat).
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      in_pkt_q <= 1'b0;
    end else if (acc) begin
      in_pkt_q <= ~mon_tlast;
    end
  end

  // Next-state decode of the update handshake/commit sequence.
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (cfg_req_valid) state_d = ST_PEND;
      end
      (state_q == ST_PEND): begin
        if (boundary) state_d = ST_COMMIT;
      end
      (state_q == ST_COMMIT): begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops any pending update.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shadow copy of the accepted request.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sh_id_q    <= '0;
      sh_entry_q <= '0;
      sh_clr_q   <= 1'b0;
    end else if (req_hs) begin
      sh_id_q    <= cfg_req_id;
      sh_entry_q <= {cfg_req_mac_must_match, cfg_req_mac,
                     cfg_req_vsid_must_match, cfg_req_vsid};
      sh_clr_q   <= req_clr;
    end
  end

  // Saturating count of cycles spent waiting for a boundary.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wait_cnt_q <= '0;
    end else if (req_hs) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_PEND && !(&wait_cnt_q)) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // Report the wait of the update being committed.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      cfg_wait_cycles <= '0;
    end else if (state_q == ST_COMMIT) begin
      cfg_wait_cycles <= wait_cnt_q;
    end
  end

  // Live table: whole entry (or whole table) written in one edge.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      tab_q <= '0;
    end else if (state_q == ST_COMMIT) begin
      if (sh_clr_q) begin
        tab_q <= '0;
      end else begin
        tab_q[PER_ID*sh_id_q +: PER_ID] <= sh_entry_q;
      end
    end
  end

endmodule

// File: tb/tb_vsid_cam_update_ctrl.sv
// tb_vsid_cam_update_ctrl: scenario tasks against a transaction model
// of the match table and the between-packets commit rule.
module tb_vsid_cam_update_ctrl;

  localparam int IDW = 4;
  localparam int WCW = 16;
  localparam int PER = 82;
  localparam int NID = 16;
  localparam int LEN = 120;

  logic                 clk = 1'b0;
  logic                 aresetn;
  logic                 cfg_req_valid;
  logic                 cfg_req_ready;
  logic [IDW-1:0]       cfg_req_id;
  logic [31:0]          cfg_req_vsid;
  logic                 cfg_req_vsid_must_match;
  logic [47:0]          cfg_req_mac;
  logic                 cfg_req_mac_must_match;
  logic                 cfg_req_clear;
  logic                 cfg_done;
  logic [WCW-1:0]       cfg_wait_cycles;
  logic                 mon_tvalid;
  logic                 mon_tready;
  logic                 mon_tlast;
  logic                 stream_hold;
  logic [PER*NID-1:0]   vsid_cam_values;

  always #5 clk = ~clk;

  vsid_cam_update_ctrl #(
    .AXIS_ID_WIDTH (IDW),
    .WAIT_CNT_WIDTH(WCW)
  ) dut (
    .aclk                   (clk),
    .aresetn                (aresetn),
    .cfg_req_valid          (cfg_req_valid),
    .cfg_req_ready          (cfg_req_ready),
    .cfg_req_id             (cfg_req_id),
    .cfg_req_vsid           (cfg_req_vsid),
    .cfg_req_vsid_must_match(cfg_req_vsid_must_match),
    .cfg_req_mac            (cfg_req_mac),
    .cfg_req_mac_must_match (cfg_req_mac_must_match),
`ifdef VSID_CAM_BULK_CLEAR_EN
    .cfg_req_clear          (cfg_req_clear),
`endif
    .cfg_done               (cfg_done),
    .cfg_wait_cycles        (cfg_wait_cycles),
    .mon_tvalid             (mon_tvalid),
    .mon_tready             (mon_tready),
    .mon_tlast              (mon_tlast),
    .stream_hold            (stream_hold),
    .vsid_cam_values        (vsid_cam_values)
  );

  int tests = 0;
  int fails = 0;

  logic [PER-1:0] ref_tab [NID];
  logic [WCW-1:0] ref_wait;

  logic [IDW-1:0] rq_id   [8];
  logic [31:0]    rq_vsid [8];
  logic [47:0]    rq_mac  [8];
  logic           rq_vmm  [8];
  logic           rq_mmm  [8];
  logic           rq_clr  [8];
  int             nreq;

  int obs_done [8];
  int n_obs;
  int last_tlast;

  function automatic logic [PER*NID-1:0] exp_vec();
    logic [PER*NID-1:0] v;
    v = '0;
    for (int j = 0; j < NID; j++) v[PER*j +: PER] = ref_tab[j];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ref();
    for (int j = 0; j < NID; j++) ref_tab[j] = '0;
    ref_wait = '0;
  endtask

  task automatic rand_req(input int k, input int id);
    rq_id[k]   = IDW'(id);
    rq_vsid[k] = $urandom;
    rq_mac[k]  = {16'($urandom), 32'($urandom)};
    rq_vmm[k]  = 1'($urandom);
    rq_mmm[k]  = 1'($urandom);
    rq_clr[k]  = 1'b0;
  endtask

  // mode 0: idle stream, 1: one packet of plen beats at pstart,
  // 2: random packets with random back-pressure
  task automatic run_scn(input int hs_at, input int mode,
                         input int plen, input int pstart);
    int             r;
    int             hs_t;
    int             exp_done;
    int             b_rem;
    logic           pend;
    logic           b_in;
    logic           b_want;
    logic           acc;
    logic [PER-1:0] sh;
    logic [IDW-1:0] sh_id;
    logic           sh_clr;
    r = 0; hs_t = 0; exp_done = -1; b_rem = 0;
    pend = 1'b0; b_in = 1'b0; b_want = 1'b0;
    sh = '0; sh_id = '0; sh_clr = 1'b0;
    n_obs = 0; last_tlast = -1;
    for (int t = 0; t < LEN; t++) begin
      if (pend && exp_done >= 0 && t == exp_done + 1) begin
        if (sh_clr) begin
          for (int j = 0; j < NID; j++) ref_tab[j] = '0;
        end else begin
          ref_tab[sh_id] = sh;
        end
        ref_wait = WCW'(exp_done - 1 - hs_t);
        pend = 1'b0;
        exp_done = -1;
      end
      tests++;
      if (cfg_req_ready !== !pend) begin
        fails++;
        $display("FAIL ready t=%0d got %0b exp %0b", t, cfg_req_ready, !pend);
      end
      tests++;
      if (stream_hold !== pend) begin
        fails++;
        $display("FAIL hold t=%0d got %0b exp %0b", t, stream_hold, pend);
      end
      tests++;
      if (cfg_done !== (pend && exp_done == t)) begin
        fails++;
        $display("FAIL done t=%0d got %0b exp %0b", t, cfg_done,
                 (pend && exp_done == t));
      end
      tests++;
      if (cfg_wait_cycles !== ref_wait) begin
        fails++;
        $display("FAIL wait t=%0d got %0d exp %0d", t, cfg_wait_cycles,
                 ref_wait);
      end
      tests++;
      if (vsid_cam_values !== exp_vec()) begin
        fails++;
        $display("FAIL table t=%0d got %h exp %h", t, vsid_cam_values,
                 exp_vec());
      end
      if (cfg_done === 1'b1) begin
        if (n_obs < 8) obs_done[n_obs] = t;
        n_obs++;
      end
      if (t >= hs_at && r < nreq) begin
        cfg_req_valid           = 1'b1;
        cfg_req_id              = rq_id[r];
        cfg_req_vsid            = rq_vsid[r];
        cfg_req_vsid_must_match = rq_vmm[r];
        cfg_req_mac             = rq_mac[r];
        cfg_req_mac_must_match  = rq_mmm[r];
        cfg_req_clear           = rq_clr[r];
        if (!pend) begin
          hs_t   = t;
          pend   = 1'b1;
          sh_id  = rq_id[r];
          sh     = {rq_mmm[r], rq_mac[r], rq_vmm[r], rq_vsid[r]};
          sh_clr = rq_clr[r];
          r++;
        end
      end else begin
        cfg_req_valid = 1'b0;
      end
      if (!b_in && !b_want) begin
        if (mode == 1 && t == pstart) begin
          b_want = 1'b1;
          b_rem  = plen;
        end
        if (mode == 2 && t < 40 && $urandom_range(0, 2) == 0) begin
          b_want = 1'b1;
          b_rem  = $urandom_range(1, 6);
        end
      end
      mon_tvalid = b_in || (b_want && !stream_hold);
      mon_tready = (mode == 2 && t < 50) ? ($urandom_range(0, 3) != 0)
                                         : 1'b1;
      mon_tlast  = mon_tvalid && b_rem == 1;
      acc = mon_tvalid && mon_tready;
      if (pend && exp_done < 0 && t > hs_t && !b_in && !acc)
        exp_done = t + 1;
      if (acc) begin
        b_want = 1'b0;
        if (b_rem == 1) begin
          b_in = 1'b0;
          last_tlast = t;
        end else begin
          b_in = 1'b1;
        end
        b_rem--;
      end
      step();
    end
    cfg_req_valid = 1'b0;
    mon_tvalid    = 1'b0;
    mon_tlast     = 1'b0;
    tests++;
    if (r != nreq || pend) begin
      fails++;
      $display("FAIL timeout got %0d handshakes exp %0d", r, nreq);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    cfg_req_valid = 1'b0;
    cfg_req_id = '0; cfg_req_vsid = '0; cfg_req_mac = '0;
    cfg_req_vsid_must_match = 1'b0; cfg_req_mac_must_match = 1'b0;
    cfg_req_clear = 1'b0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    clear_ref();
    step();
    step();
    aresetn = 1'b1;
    tests++;
    if (cfg_req_ready !== 1'b1) begin
      fails++; $display("FAIL rst_ready got %0b exp 1", cfg_req_ready);
    end
    tests++;
    if (stream_hold !== 1'b0 || cfg_done !== 1'b0) begin
      fails++;
      $display("FAIL rst_hold_done got %0b%0b exp 00", stream_hold, cfg_done);
    end
    tests++;
    if (cfg_wait_cycles !== '0 || vsid_cam_values !== '0) begin
      fails++;
      $display("FAIL rst_regs got wait %0d table %h exp 0", cfg_wait_cycles,
               vsid_cam_values);
    end
    step();
  endtask

  task automatic test_idle_update();
    logic [PER-1:0] want;
    nreq = 1;
    rq_id[0] = 4'd3; rq_vsid[0] = 32'h00ABCDEF; rq_vmm[0] = 1'b1;
    rq_mac[0] = 48'h0A0B0C0D0E0F; rq_mmm[0] = 1'b1; rq_clr[0] = 1'b0;
    run_scn(1, 0, 0, 0);
    want = {1'b1, 48'h0A0B0C0D0E0F, 1'b1, 32'h00ABCDEF};
    tests++;
    if (n_obs != 1 || obs_done[0] != 3) begin
      fails++;
      $display("FAIL idle_latency got %0d pulses at %0d exp 1 at 3", n_obs,
               obs_done[0]);
    end
    tests++;
    if (vsid_cam_values[PER*3 +: PER] !== want || cfg_wait_cycles !== 16'd1)
    begin
      fails++;
      $display("FAIL idle_entry got %h wait %0d exp %h wait 1",
               vsid_cam_values[PER*3 +: PER], cfg_wait_cycles, want);
    end
  endtask

  task automatic test_mid_packet();
    nreq = 1;
    rand_req(0, 0);
    rq_vsid[0] = 32'h1234_5678;
    run_scn(2, 1, 10, 0);
    tests++;
    if (n_obs != 1 || obs_done[0] <= last_tlast + 1) begin
      fails++;
      $display("FAIL mid_pkt_commit got done %0d tlast %0d exp done>tlast+1",
               obs_done[0], last_tlast);
    end
    tests++;
    if (cfg_wait_cycles < 16'd8) begin
      fails++;
      $display("FAIL mid_pkt_wait got %0d exp >=8", cfg_wait_cycles);
    end
  endtask

  task automatic test_same_cycle_start();
    nreq = 1;
    rand_req(0, 7);
    run_scn(3, 1, 4, 3);
    tests++;
    if (n_obs != 1 || obs_done[0] <= last_tlast) begin
      fails++;
      $display("FAIL same_cyc got done %0d tlast %0d exp done>tlast",
               obs_done[0], last_tlast);
    end
  endtask

  task automatic test_back_to_back();
    nreq = 2;
    rand_req(0, 1);
    rand_req(1, 2);
    run_scn(1, 0, 0, 0);
    tests++;
    if (n_obs != 2 || obs_done[0] != 3 || obs_done[1] - obs_done[0] != 3)
    begin
      fails++;
      $display("FAIL b2b got %0d pulses at %0d,%0d exp 2 at 3,6", n_obs,
               obs_done[0], obs_done[1]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      nreq = 3;
      for (int q = 0; q < 3; q++) rand_req(q, $urandom_range(0, NID - 1));
      run_scn($urandom_range(0, 20), 2, 0, 0);
    end
  endtask

  task automatic test_reset_pend();
    aresetn = 1'b1;
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0;
    cfg_req_valid = 1'b1;
    cfg_req_id = 4'd5;
    cfg_req_vsid = 32'hDEAD_BEEF; cfg_req_vsid_must_match = 1'b1;
    cfg_req_mac = 48'h1122_3344_5566; cfg_req_mac_must_match = 1'b1;
    cfg_req_clear = 1'b0;
    tests++;
    if (cfg_req_ready !== 1'b1) begin
      fails++; $display("FAIL rp_ready0 got %0b exp 1", cfg_req_ready);
    end
    step();
    cfg_req_valid = 1'b0;
    step();
    step();
    tests++;
    if (stream_hold !== 1'b1) begin
      fails++; $display("FAIL rp_pend got hold %0b exp 1", stream_hold);
    end
    aresetn = 1'b0;
    mon_tvalid = 1'b0;
    step();
    aresetn = 1'b1;
    clear_ref();
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (cfg_req_ready !== 1'b1 || stream_hold !== 1'b0 ||
          cfg_done !== 1'b0) begin
        fails++;
        $display("FAIL rp_ctrl k=%0d got rdy %0b hold %0b done %0b exp 100",
                 k, cfg_req_ready, stream_hold, cfg_done);
      end
      tests++;
      if (vsid_cam_values !== exp_vec() || cfg_wait_cycles !== ref_wait)
      begin
        fails++;
        $display("FAIL rp_table k=%0d got entry5 %h wait %0d exp 0", k,
                 vsid_cam_values[PER*5 +: PER], cfg_wait_cycles);
      end
      step();
    end
  endtask

`ifdef VSID_CAM_BULK_CLEAR_EN
  task automatic test_bulk_clear();
    nreq = 3;
    for (int q = 0; q < 3; q++) rand_req(q, q + 1);
    run_scn(0, 0, 0, 0);
    nreq = 1;
    rand_req(0, 2);
    rq_clr[0] = 1'b1;
    run_scn(1, 2, 0, 0);
    tests++;
    if (n_obs != 1 || vsid_cam_values !== '0) begin
      fails++;
      $display("FAIL bulk_clear got %0d pulses table %h exp 1 and 0", n_obs,
               vsid_cam_values);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_update();
    test_mid_packet();
    test_same_cycle_start();
    test_back_to_back();
    test_random();
    test_reset_pend();
`ifdef VSID_CAM_BULK_CLEAR_EN
    test_bulk_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
